// File: rtl/audio_tone_gen_if.sv
// Tone generator control and stereo DAC stream bundle.
// master = tone generator, slave = game logic plus codec.
interface audio_tone_gen_if #(
  parameter int DATA_W = 16
) ();

  logic              start;
  logic              stop;
  logic [15:0]       half_period;
  logic [15:0]       duration;
  logic [14:0]       amplitude;
  logic [DATA_W-1:0] left_data;
  logic              left_valid;
  logic              left_ready;
  logic [DATA_W-1:0] right_data;
  logic              right_valid;
  logic              right_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  stop,
    input  half_period,
    input  duration,
    input  amplitude,
    output left_data,
    output left_valid,
    input  left_ready,
    output right_data,
    output right_valid,
    input  right_ready,
    output busy,
    output done
  );

  modport slave (
    output start,
    output stop,
    output half_period,
    output duration,
    output amplitude,
    input  left_data,
    input  left_valid,
    output left_ready,
    input  right_data,
    input  right_valid,
    output right_ready,
    input  busy,
    input  done
  );

endinterface

// File: rtl/audio_tone_gen.sv
// Ready-paced square-wave tone generator for the codec DAC stream.
// Emits a fixed count of stereo samples with optional decay envelope.
module audio_tone_gen #(
  parameter int DATA_W         = 16,
  parameter int DECAY_EN       = 1,
  parameter int DECAY_INTERVAL = 256,
  parameter int DECAY_SHIFT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  audio_tone_gen_if.master  io
);

  localparam int DCW =
    (DECAY_INTERVAL > 1) ? $clog2(DECAY_INTERVAL) : 1;
  localparam logic [DCW-1:0] DC_LAST =
    DCW'(DECAY_INTERVAL - 1);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_ADV,
    S_FIN
  } state_t;

  state_t            state_q;
  logic [15:0]       hp_q;
  logic [15:0]       dur_q;
  logic [14:0]       amp_q;
  logic [15:0]       smp_q;
  logic [15:0]       ph_q;
  logic [DCW-1:0]    dc_q;
  logic              pol_q;
  logic              stp_q;
  logic              lv_q;
  logic              rv_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;

  logic [15:0]       smp_d;
  logic [15:0]       ph_d;
  logic [DCW-1:0]    dc_d;
  logic              pol_d;
  logic [14:0]       amp_d;
  logic              last;
  logic              both_acc;

  function automatic logic [DATA_W-1:0] sval(
    input logic        p,
    input logic [14:0] a,
    input logic [15:0] h
  );
    logic [DATA_W-1:0] m;
    m    = DATA_W'(a);
    sval = '0;
    if (h != 16'd0)
      sval = p ? (~m + ONE) : m;
  endfunction

  // Next tone/envelope counters applied when a sample retires.
  always_comb begin
    smp_d    = smp_q + 16'd1;
    ph_d     = ph_q + 16'd1;
    pol_d    = pol_q;
    dc_d     = dc_q;
    amp_d    = amp_q;
    if (ph_q == hp_q - 16'd1) begin
      ph_d  = 16'd0;
      pol_d = ~pol_q;
    end
    if (DECAY_EN != 0) begin
      if (dc_q == DC_LAST) begin
        dc_d  = '0;
        amp_d = amp_q - (amp_q >> DECAY_SHIFT);
      end else begin
        dc_d  = dc_q + DCW'(1);
      end
    end
    last     = ({1'b0, smp_q} + 17'd1)
             >= {1'b0, dur_q};
    both_acc = (~lv_q | io.left_ready)
             & (~rv_q | io.right_ready);
  end

  // Tone sequencer with registered stream and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hp_q    <= '0;
      dur_q   <= '0;
      amp_q   <= '0;
      smp_q   <= '0;
      ph_q    <= '0;
      dc_q    <= '0;
      pol_q   <= 1'b0;
      stp_q   <= 1'b0;
      lv_q    <= 1'b0;
      rv_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (io.start) begin
            hp_q   <= io.half_period;
            dur_q  <= io.duration;
            amp_q  <= io.amplitude;
            smp_q  <= '0;
            ph_q   <= '0;
            dc_q   <= '0;
            pol_q  <= 1'b0;
            stp_q  <= 1'b0;
            busy_q <= 1'b1;
            if (io.duration == 16'd0) begin
              // Empty tone: one busy cycle, no samples.
              state_q <= S_ADV;
            end else begin
              state_q <= S_EMIT;
              lv_q    <= 1'b1;
              rv_q    <= 1'b1;
              data_q  <= sval(1'b0, io.amplitude,
                              io.half_period);
            end
          end
        end
        S_EMIT: begin
          if (io.stop)
            stp_q <= 1'b1;
          if (lv_q && io.left_ready)
            lv_q <= 1'b0;
          if (rv_q && io.right_ready)
            rv_q <= 1'b0;
          if (both_acc)
            state_q <= S_ADV;
        end
        S_ADV: begin
          smp_q <= smp_d;
          ph_q  <= ph_d;
          pol_q <= pol_d;
          dc_q  <= dc_d;
          amp_q <= amp_d;
          if (last || stp_q || io.stop) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_EMIT;
            lv_q    <= 1'b1;
            rv_q    <= 1'b1;
            data_q  <= sval(pol_d, amp_d, hp_q);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign io.left_data   = data_q;
  assign io.right_data  = data_q;
  assign io.left_valid  = lv_q;
  assign io.right_valid = rv_q;
  assign io.busy        = busy_q;
  assign io.done        = done_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen: three envelope configs in lockstep.
// Reference model computes each sample from its index.
module tb_audio_tone_gen;

  localparam int ND = 3;
  localparam int DEN [ND] = '{0, 1, 1};
  localparam int DI  [ND] = '{256, 1, 3};
  localparam int DS  [ND] = '{4, 1, 2};

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, lrdy, rrdy;
  logic [15:0] hp_in, dur_in;
  logic [14:0] amp_in;

  logic [15:0] ld [ND];
  logic [15:0] rd [ND];
  logic        lv [ND];
  logic        rv [ND];
  logic        bs [ND];
  logic        dn [ND];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  int m_hp, m_dur, m_amp;
  bit act     [ND];
  bit stopped [ND];
  int lacc    [ND];
  int racc    [ND];
  int nexp    [ND];
  int donec   [ND];

  int cap = 0;
  int lq[$];
  int lcy[$];
  int lrq[$];
  int rrq[$];
  int lrun = 0;
  int rrun = 0;
  int dcy  = 0;

  int rmode = 0;
  int rcnt  = 0;
  bit rel   = 1'b0;

  int E2 [8] = '{1000, 1000, -1000, -1000,
                 1000, 1000, -1000, -1000};
  int E4 [6] = '{16, -8, 4, -2, 1, -1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    audio_tone_gen_if #(.DATA_W(16)) ifc ();
    assign ifc.start       = start;
    assign ifc.stop        = stop;
    assign ifc.half_period = hp_in;
    assign ifc.duration    = dur_in;
    assign ifc.amplitude   = amp_in;
    assign ifc.left_ready  = lrdy;
    assign ifc.right_ready = rrdy;
    assign ld[g] = ifc.left_data;
    assign rd[g] = ifc.right_data;
    assign lv[g] = ifc.left_valid;
    assign rv[g] = ifc.right_valid;
    assign bs[g] = ifc.busy;
    assign dn[g] = ifc.done;
    audio_tone_gen #(
      .DATA_W        (16),
      .DECAY_EN      (DEN[g]),
      .DECAY_INTERVAL(DI[g]),
      .DECAY_SHIFT   (DS[g])
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .io   (ifc)
    );
  end

  task automatic chk(string nm, int a, int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, a, e, cyc);
    end
  endtask

  // Sample k of the current tone, straight from the tone rules.
  function automatic int expv(int g, int k);
    int a;
    a = m_amp;
    if (DEN[g] != 0) begin
      for (int i = 0; i < k / DI[g]; i++) begin
        if ((a >> DS[g]) == 0) break;
        a = a - (a >> DS[g]);
      end
    end
    if (m_hp == 0) return 0;
    return (((k / m_hp) % 2) != 0) ? -a : a;
  endfunction

  // Ready pattern generator, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: begin
        lrdy = 1'b1;
        rrdy = 1'b1;
      end
      1: begin
        lrdy = ($urandom_range(0, 3) != 0);
        rrdy = ($urandom_range(0, 3) != 0);
      end
      2: begin
        lrdy = 1'b1;
        if (rv[0]) rcnt++;
        else rcnt = 0;
        rrdy = (rcnt >= 6);
      end
      3: begin
        lrdy = (lacc[0] != 2) || rel;
        rrdy = (lacc[0] != 2) || rel;
      end
      default: begin
        lrdy = 1'b0;
        rrdy = 1'b0;
      end
    endcase
  end

  // Per-cycle comparison of every DUT against the model.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      for (int g = 0; g < ND; g++) act[g] = 1'b0;
      lrun = 0;
      rrun = 0;
    end else begin
      for (int g = 0; g < ND; g++) begin
        int n;
        if (stop && bs[g] && act[g] && !stopped[g]) begin
          stopped[g] = 1'b1;
          if (lv[g] || rv[g])
            n = ((lacc[g] < racc[g]) ? lacc[g] : racc[g]) + 1;
          else
            n = lacc[g];
          if (n < nexp[g]) nexp[g] = n;
        end
        if (lv[g]) begin
          chk("l_in_tone", int'(act[g]), 1);
          chk("l_busy", int'(bs[g]), 1);
          chk("l_order", int'(lacc[g] <= racc[g] &&
                              lacc[g] < nexp[g]), 1);
          chk("l_data", int'($signed(ld[g])),
              expv(g, lacc[g]));
        end
        if (rv[g]) begin
          chk("r_in_tone", int'(act[g]), 1);
          chk("r_busy", int'(bs[g]), 1);
          chk("r_order", int'(racc[g] <= lacc[g] &&
                              racc[g] < nexp[g]), 1);
          chk("r_data", int'($signed(rd[g])),
              expv(g, racc[g]));
        end
        if (g == cap) begin
          if (lv[g]) lrun++;
          if (rv[g]) rrun++;
          if (lv[g] && lrdy) begin
            lq.push_back(int'($signed(ld[g])));
            lcy.push_back(cyc);
            lrq.push_back(lrun);
            lrun = 0;
          end
          if (rv[g] && rrdy) begin
            rrq.push_back(rrun);
            rrun = 0;
          end
          if (dn[g]) dcy = cyc;
        end
        if (lv[g] && lrdy) lacc[g]++;
        if (rv[g] && rrdy) racc[g]++;
        if (dn[g]) begin
          chk("done_l_cnt", lacc[g], nexp[g]);
          chk("done_r_cnt", racc[g], nexp[g]);
          chk("done_busy", int'(bs[g]), 0);
          donec[g]++;
          act[g] = 1'b0;
        end
      end
    end
  end

  task automatic clearq();
    lq.delete();
    lcy.delete();
    lrq.delete();
    rrq.delete();
    lrun = 0;
    rrun = 0;
    dcy  = 0;
  endtask

  task automatic start_tone(int h, int d, int a);
    @(posedge clk);
    #1;
    hp_in  = 16'(h);
    dur_in = 16'(d);
    amp_in = 15'(a);
    start  = 1'b1;
    m_hp   = h;
    m_dur  = d;
    m_amp  = a;
    for (int g = 0; g < ND; g++) begin
      act[g]     = 1'b1;
      stopped[g] = 1'b0;
      lacc[g]    = 0;
      racc[g]    = 0;
      nexp[g]    = d;
      donec[g]   = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int lim);
    int k;
    k = 0;
    while ((act[0] || act[1] || act[2]) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("timeout", int'(act[0] || act[1] || act[2]), 0);
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < ND; g++)
      chk("done_once", donec[g], 1);
  endtask

  task automatic chk_zero(string nm);
    for (int g = 0; g < ND; g++) begin
      chk({nm, "_lv"}, int'(lv[g]), 0);
      chk({nm, "_rv"}, int'(rv[g]), 0);
      chk({nm, "_busy"}, int'(bs[g]), 0);
      chk({nm, "_done"}, int'(dn[g]), 0);
      chk({nm, "_ldata"}, int'(ld[g]), 0);
      chk({nm, "_rdata"}, int'(rd[g]), 0);
    end
  endtask

  initial begin
    int k;
    reset  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    hp_in  = '0;
    dur_in = '0;
    amp_in = '0;
    lrdy   = 1'b0;
    rrdy   = 1'b0;
    for (int g = 0; g < ND; g++) begin
      act[g]   = 1'b0;
      lacc[g]  = 0;
      racc[g]  = 0;
      nexp[g]  = 0;
      donec[g] = 0;
    end
    #12;
    chk_zero("rst");
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset mid-EMIT with valids stalled high.
    rmode = 4;
    start_tone(3, 10, 1234);
    repeat (3) @(posedge clk);
    #3;
    chk("d1_pre_lv", int'(lv[0]), 1);
    reset = 1'b0;
    #1;
    chk_zero("d1_async");
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int g = 0; g < ND; g++) begin
      chk("d1_no_done", donec[g], 0);
      chk("d1_idle", int'(bs[g]), 0);
    end

    // Basic square wave, full-rate readies.
    rmode = 0;
    cap   = 0;
    clearq();
    start_tone(2, 8, 1000);
    chk("d2_lat_busy", int'(bs[0]), 1);
    chk("d2_lat_lv", int'(lv[0]), 1);
    chk("d2_lat_rv", int'(rv[0]), 1);
    wait_done(200);
    chk("d2_n", lq.size(), 8);
    for (int i = 0; i < lq.size() && i < 8; i++)
      chk("d2_smp", lq[i], E2[i]);
    for (int i = 1; i < lcy.size(); i++)
      chk("d2_gap", lcy[i] - lcy[i-1], 2);
    if (lcy.size() == 8)
      chk("d2_done_lat", dcy - lcy[7], 2);

    // Right channel back-pressure.
    rmode = 2;
    rcnt  = 0;
    clearq();
    start_tone(3, 4, 500);
    wait_done(500);
    rmode = 0;
    chk("d3_n", lq.size(), 4);
    chk("d3_rn", rrq.size(), 4);
    foreach (rrq[i]) chk("d3_rhold", rrq[i], 6);
    foreach (lrq[i]) chk("d3_lhold", lrq[i], 1);

    // Envelope halving to its floor.
    cap = 1;
    clearq();
    start_tone(0, 6, 16);
    wait_done(200);
    chk("d4_n0", lq.size(), 6);
    foreach (lq[i]) chk("d4_silent", lq[i], 0);
    clearq();
    start_tone(1, 6, 16);
    wait_done(200);
    chk("d4_n1", lq.size(), 6);
    for (int i = 0; i < lq.size() && i < 6; i++)
      chk("d4_env", lq[i], E4[i]);

    // Zero duration.
    cap = 0;
    clearq();
    start_tone(5, 0, 100);
    chk("d5_busy", int'(bs[0]), 1);
    chk("d5_lv", int'(lv[0]), 0);
    chk("d5_done0", int'(dn[0]), 0);
    @(posedge clk);
    #1;
    chk("d5_done1", int'(dn[0]), 1);
    chk("d5_busy1", int'(bs[0]), 0);
    wait_done(50);
    chk("d5_nsmp", lq.size(), 0);

    // Stop while the third sample is stalled.
    rmode = 3;
    rel   = 1'b0;
    clearq();
    start_tone(4, 10, 2000);
    k = 0;
    while (lacc[0] != 2 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("d6_reach", lacc[0], 2);
    repeat (4) @(posedge clk);
    #1;
    stop   = 1'b1;
    start  = 1'b1;
    hp_in  = 16'd7;
    dur_in = 16'd3;
    amp_in = 15'd5;
    @(posedge clk);
    #1;
    stop  = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rel = 1'b1;
    wait_done(200);
    rmode = 0;
    rel   = 1'b0;
    chk("d6_n", lq.size(), 3);
    if (lq.size() == 3)
      chk("d6_smp3", lq[2], 2000);

    // Random tones, random readies, occasional stop.
    rmode = 1;
    for (int t = 0; t < 30; t++) begin
      start_tone(int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 24)),
                 int'($urandom_range(0, 32767)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
      end
      wait_done(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/audio_tone_gen.md
Name: audio_tone_gen

Overview:
- Sample-rate-paced square-wave tone generator that feeds the to_dac_left/right_channel streaming inputs of the audio codec core.
- Game logic issues a start with pitch, duration and amplitude. The block emits a fixed number of stereo samples with an optional exponential decay envelope, then pulses done.
- Sample pacing comes entirely from the codec's ready signals. There is no internal sample-rate timer.

Parameters:
DATA_W, 16, sample width; matches the codec channel width.
DECAY_EN, 1, 1 enables the decay envelope; 0 holds amplitude constant.
DECAY_INTERVAL, 256, number of accepted samples between envelope steps; must be at least 1.
DECAY_SHIFT, 4, envelope step is amp_cur minus (amp_cur >> DECAY_SHIFT); must be at least 1.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
start  in  1  one-cycle request to begin a tone; sampled only in IDLE.
stop  in  1  abort request; honoured at the next sample boundary.
half_period  in  16  samples per half-cycle of the square wave; 0 = silence.
duration  in  16  total stereo samples to emit.
amplitude  in  15  peak magnitude, unsigned.
left_data  out  DATA_W  two's-complement sample to the DAC left channel.
left_valid  out  1  left sample valid.
left_ready  in  1  DAC left channel ready.
right_data  out  DATA_W  sample to the DAC right channel; same value as left_data.
right_valid  out  1  right sample valid.
right_ready  in  1  DAC right channel ready.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when the tone completes or is aborted.

Behaviour:
- Reset, asynchronous while reset=0:
  - state=IDLE.
  - All outputs 0.
  - Internal counters, amp_cur and polarity cleared.
  - Takes effect mid-tone: valids drop immediately and no done pulse is issued.
- States:
  - IDLE: on start=1, latch half_period, duration and amplitude.
    - duration=0: go to FINISH (no samples emitted).
    - Otherwise: go to EMIT.
  - EMIT: present one stereo sample. left_valid and right_valid are asserted together and behave independently.
    - Each valid stays high, with its data held stable, until its ready is seen high on a clock edge. That valid then deasserts.
    - When both channels have accepted (same cycle or different cycles), go to ADVANCE.
  - ADVANCE, one cycle, no valids:
    - sample_cnt++.
    - Tone counter: phase_cnt++. If phase_cnt reaches half_period-1, set phase_cnt=0 and toggle polarity.
    - Envelope: if DECAY_EN=1, decay_cnt++. When decay_cnt reaches DECAY_INTERVAL-1, set decay_cnt=0 and amp_cur = amp_cur - (amp_cur >> DECAY_SHIFT).
    - If sample_cnt==duration or a stop is pending, go to FINISH. Otherwise go to EMIT.
  - FINISH, one cycle: done=1, busy=0, then return to IDLE.
- Sample value:
  - polarity=0 gives +amp_cur, zero-extended to DATA_W.
  - polarity=1 gives the two's-complement negation of amp_cur.
  - half_period=0 gives 0 for every sample, counters still run.
- Tone start values: polarity starts at 0 and amp_cur starts at the latched amplitude.
- Latency and throughput:
  - start at edge N gives busy=1 and both valids=1 after edge N+1.
  - Maximum throughput is one sample per 2 cycles when ready is held high (EMIT plus ADVANCE).
- stop:
  - Recorded in a pending flag whenever busy=1.
  - Never drops a presented valid.
  - The tone ends after the sample currently in EMIT is fully accepted.
  - stop in IDLE is ignored.
- start while busy: ignored; the parameters of the active tone do not change.
- start and stop in the same IDLE cycle: start wins; stop is ignored.
- Envelope floor:
  - amp_cur decays to a fixed point once amp_cur >> DECAY_SHIFT becomes 0.
  - amp_cur never goes negative or wraps.
- Counter widths: sample_cnt and phase_cnt are 16 bits. duration=65535 is emitted fully without wrap.

Test Plan:
- Directed 1: reset=0 mid-EMIT with valids high -> valids, busy, done, left_data and right_data go to 0 at once; after release, no done pulse.
- Directed 2: start with half_period=2, duration=8, amplitude=1000, DECAY_EN=0, ready tied 1 -> samples +1000,+1000,-1000,-1000,+1000,+1000,-1000,-1000 on both channels, one per 2 cycles; done pulses once, 1 cycle after the 8th ADVANCE.
- Directed 3: left_ready held 1, right_ready low for 5 cycles per sample -> left_valid drops after 1 cycle; right_valid is held with data stable for 6 cycles; the next sample is presented only after both accept; no sample is duplicated or lost.
- Directed 4: DECAY_INTERVAL=1, DECAY_SHIFT=1, amplitude=16, half_period=0 -> all samples are 0 while internal amp_cur goes 16,8,4,2,1,1; the floor holds at 1 and never wraps.
- Directed 5: duration=0 -> no valid is ever asserted; busy=1 for 1 cycle, then done pulses.
- Directed 6: stop asserted while sample 3 of 10 is stalled by ready=0 -> sample 3 is still delivered intact, then FINISH; exactly 3 samples and 1 done pulse; start during busy has no effect.
